// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side bundle of the shared mux: request levels, data slices, grant and muxed data.
// Optional lock line present only when MUX_ARB_LOCK_EN is defined.
interface mux8_rr_arbiter_if #(parameter int DATA_W = 1);
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [SEL_W-1:0]          sel;
  logic                      valid;
  logic [DATA_W-1:0]         data_out;
`ifdef MUX_ARB_LOCK_EN
  logic                      lock;

  modport master (output req, data_in, lock, input gnt, sel, valid, data_out);
  modport slave  (input req, data_in, lock, output gnt, sel, valid, data_out);
`else
  modport master (output req, data_in, input gnt, sel, valid, data_out);
  modport slave  (input req, data_in, output gnt, sel, valid, data_out);
`endif
endinterface

// File: rtl/rr_pick8.sv
// Rotating-priority search: first set bit of req scanning start, start+1, ... modulo 8.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [SEL_W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = start;
    pos   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = start + SEL_W'(k);  // 3-bit add wraps 7 -> 0
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 data mux, with bounded grant hold.
// Define MUX_ARB_LOCK_EN to add a lock input that suppresses hold-limit preemption.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
)(
  input  logic                clk,
  input  logic                reset,
  mux8_rr_arbiter_if.slave    bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int NP = 2;  // pick 0: fresh grant from ptr, pick 1: handover from cur+1

  arb_state_e       state, state_n;
  logic [SEL_W-1:0] cur, cur_n, ptr, ptr_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             lock_w;

  logic [NP-1:0][NUM_REQ-1:0] pk_req;
  logic [NP-1:0][SEL_W-1:0]   pk_start, pk_idx;
  logic [NP-1:0]              pk_found;

`ifdef MUX_ARB_LOCK_EN
  assign lock_w = bus.lock;
`else
  assign lock_w = 1'b0;
`endif

  assign pk_req[0]   = bus.req;
  assign pk_start[0] = ptr;
  assign pk_req[1]   = bus.req & ~onehot(cur);
  assign pk_start[1] = cur + SEL_W'(1);

  for (genvar g = 0; g < NP; g++) begin : g_pick
    rr_pick8 u_pick (
      .req   (pk_req[g]),
      .start (pk_start[g]),
      .found (pk_found[g]),
      .idx   (pk_idx[g])
    );
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pk_found[0]) begin
          state_n = GRANT;
          cur_n   = pk_idx[0];
          ptr_n   = pk_idx[0] + SEL_W'(1);
          hold_n  = HW'(1);
        end
      end
      GRANT: begin
        if (!bus.req[cur]) begin
          if (pk_found[1]) begin
            cur_n  = pk_idx[1];
            ptr_n  = pk_idx[1] + SEL_W'(1);
            hold_n = HW'(1);
          end else begin
            state_n = IDLE;
            hold_n  = '0;
          end
        end else if (hold_cnt < HW'(MAX_HOLD)) begin
          hold_n = hold_cnt + HW'(1);
        end else if (pk_found[1] && !lock_w) begin
          cur_n  = pk_idx[1];
          ptr_n  = pk_idx[1] + SEL_W'(1);
          hold_n = HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      bus.gnt   <= '0;
      bus.valid <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      bus.gnt   <= (state_n == GRANT) ? onehot(cur_n) : '0;
      bus.valid <= (state_n == GRANT);
    end
  end

  // sel holds the last owner while idle; the data path is gated by valid instead.
  assign bus.sel      = cur;
  assign bus.data_out = bus.valid ? bus.data_in[cur*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed checks of mux8_rr_arbiter with MAX_HOLD=4 and 8-bit data slices.
module tb_mux8_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;
  logic [63:0] din;

  mux8_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux8_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.data_in = din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expg(input string tag, input logic [7:0] g, input logic [2:0] s);
    logic [7:0] d;
    d = (g != 8'h00) ? din[s*8 +: 8] : 8'h00;
    chk({tag, ".gnt"},   32'(bus.gnt),      32'(g));
    chk({tag, ".valid"}, 32'(bus.valid),    32'(g != 8'h00));
    chk({tag, ".sel"},   32'(bus.sel),      32'(s));
    chk({tag, ".data"},  32'(bus.data_out), 32'(d));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'hA0 + 8'(i);
    reset   = 1'b1;
    bus.req = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      cyc();
      expg("rst", 8'h00, 3'd0);
    end

    // ch2 and ch5 alternate every MAX_HOLD cycles with no bubble
    reset   = 1'b0;
    bus.req = 8'b0010_0100;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (i < 4)      expg("rr_a", 8'h04, 3'd2);
      else if (i < 8) expg("rr_b", 8'h20, 3'd5);
      else            expg("rr_c", 8'h04, 3'd2);
    end
    bus.req = 8'h00;
    cyc(); expg("idle1", 8'h00, 3'd2);

    // lone requester keeps the grant past MAX_HOLD
    bus.req = 8'h80;
    for (int i = 0; i < 10; i++) begin
      cyc(); expg("solo7", 8'h80, 3'd7);
    end
    bus.req = 8'h00;
    cyc(); expg("drop7", 8'h00, 3'd7);

    // wrap: ptr back at 0, ch0 beats ch6; data_out follows live data_in
    bus.req = 8'b0100_0001;
    cyc(); expg("wrap0", 8'h01, 3'd0);
    din[7:0] = 8'h5A;
    #1;
    chk("track0", 32'(bus.data_out), 32'h5A);
    bus.req = 8'b0100_0000;
    cyc(); expg("hand6", 8'h40, 3'd6);
    bus.req = 8'h00;
    cyc(); expg("idle6", 8'h00, 3'd6);

    // ch3 drops after 2 cycles; ch5 then gets a full fresh hold window
    bus.req = 8'h08;
    cyc(); expg("ch3a", 8'h08, 3'd3);
    bus.req = 8'b0010_1000;
    cyc(); expg("ch3b", 8'h08, 3'd3);
    bus.req = 8'b0010_0000;
    cyc(); expg("ch5a", 8'h20, 3'd5);
    bus.req = 8'b0010_1000;
    for (int i = 0; i < 3; i++) begin
      cyc(); expg("ch5h", 8'h20, 3'd5);
    end
    cyc(); expg("back3", 8'h08, 3'd3);
    bus.req = 8'h00;
    cyc(); expg("idle3", 8'h00, 3'd3);

    // reset mid-grant clears outputs and ptr
    bus.req = 8'h04;
    cyc(); expg("ch2", 8'h04, 3'd2);
    reset = 1'b1;
    cyc(); expg("midrst", 8'h00, 3'd0);
    reset   = 1'b0;
    bus.req = 8'h06;
    cyc(); expg("ptr0", 8'h02, 3'd1);
    bus.req = 8'h00;
    cyc(); expg("idle1b", 8'h00, 3'd1);

`ifdef MUX_ARB_LOCK_EN
    // lock holds ch2 past MAX_HOLD until released
    bus.lock = 1'b1;
    bus.req  = 8'b0010_0100;
    for (int i = 0; i < 8; i++) begin
      cyc(); expg("lock2", 8'h04, 3'd2);
    end
    bus.lock = 1'b0;
    cyc(); expg("unlock5", 8'h20, 3'd5);
    bus.req = 8'h00;
    cyc(); expg("idle5", 8'h00, 3'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
